// File: rtl/mem_arb_ctrl.sv
// rtl/mem_arb_ctrl.sv - two-port arbiter in front of a single-command memory interface
//
// Serves one of two requesters per transaction through IDLE -> ISSUE -> WAIT -> RESP.
// A request sampled in IDLE is registered onto the memory command, held valid for one
// cycle, then the block waits for m_ready, returns read data to the winner with a
// one-cycle ack, and spends one dead cycle before it can grant again.
//
// Configuration macro: MEM_ARB_FIXED_PRIO_EN
//   undefined : round-robin between simultaneous requesters (port 0 first after reset)
//   defined   : port 0 always wins simultaneous requests
//
// Ports
//   clk, res                      clock, synchronous active-high reset
//   pN_valid, pN_wr_rd            requester command valid, write(1)/read(0)
//   pN_addr, pN_wdata             requester address and write data
//   pN_ack, pN_rdata              one-cycle completion pulse, read data valid with ack
//   m_valid, m_wr_rd              registered memory command valid and direction
//   m_addr, m_wdata               registered memory address and write data
//   m_ready, m_rdata              memory completion and read data
//   busy                          high whenever not in IDLE

module mem_arb_ctrl #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  res,
   input  logic                  p0_valid,
   input  logic                  p0_wr_rd,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [WIDTH-1:0]      p0_wdata,
   output logic                  p0_ack,
   output logic [WIDTH-1:0]      p0_rdata,
   input  logic                  p1_valid,
   input  logic                  p1_wr_rd,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [WIDTH-1:0]      p1_wdata,
   output logic                  p1_ack,
   output logic [WIDTH-1:0]      p1_rdata,
   output logic                  m_valid,
   output logic                  m_wr_rd,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic [WIDTH-1:0]      m_wdata,
   input  logic                  m_ready,
   input  logic [WIDTH-1:0]      m_rdata,
   output logic                  busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic                  m_valid_q, m_valid_d;
   logic                  m_wr_rd_q, m_wr_rd_d;
   logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
   logic [WIDTH-1:0]      m_wdata_q, m_wdata_d;
   logic                  grant_q, grant_d;
   logic [1:0]            ack_q, ack_d;
   logic [WIDTH-1:0]      p0_rdata_q, p0_rdata_d;
   logic [WIDTH-1:0]      p1_rdata_q, p1_rdata_d;

   logic any_req;
   logic win;

   assign any_req = p0_valid | p1_valid;

`ifdef MEM_ARB_FIXED_PRIO_EN
   // Port 0 takes any cycle it asks for; no grant history is kept.
   always_comb begin
      win = p0_valid ? 1'b0 : 1'b1;
   end
`else
   logic last_grant_q, last_grant_d;

   // On contention the port that did not win last time is chosen;
   // a lone requester wins regardless of history.
   always_comb begin
      if (p0_valid && p1_valid) begin
         win = ~last_grant_q;
      end else begin
         win = ~p0_valid;
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (state_q == ST_IDLE && any_req) begin
         last_grant_d = win;
      end
   end

   // Reset value 1 makes port 0 the first contention winner.
   always_ff @(posedge clk) begin
      if (res) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`endif

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (any_req) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (m_ready) state_d = ST_RESP;
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      m_valid_d  = 1'b0;
      m_wr_rd_d  = m_wr_rd_q;
      m_addr_d   = m_addr_q;
      m_wdata_d  = m_wdata_q;
      grant_d    = grant_q;
      ack_d      = 2'b00;
      p0_rdata_d = p0_rdata_q;
      p1_rdata_d = p1_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               m_valid_d = 1'b1;
               grant_d   = win;
               m_wr_rd_d = win ? p1_wr_rd : p0_wr_rd;
               m_addr_d  = win ? p1_addr  : p0_addr;
               m_wdata_d = win ? p1_wdata : p0_wdata;
            end
         end
         ST_WAIT: begin
            if (m_ready) begin
               ack_d[grant_q] = 1'b1;
               // Writes leave the requester's read data untouched.
               if (!m_wr_rd_q) begin
                  if (grant_q) begin
                     p1_rdata_d = m_rdata;
                  end else begin
                     p0_rdata_d = m_rdata;
                  end
               end
            end
         end
         default: begin
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (res) begin
         state_q    <= ST_IDLE;
         m_valid_q  <= 1'b0;
         m_wr_rd_q  <= 1'b0;
         m_addr_q   <= '0;
         m_wdata_q  <= '0;
         grant_q    <= 1'b0;
         ack_q      <= 2'b00;
         p0_rdata_q <= '0;
         p1_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         m_valid_q  <= m_valid_d;
         m_wr_rd_q  <= m_wr_rd_d;
         m_addr_q   <= m_addr_d;
         m_wdata_q  <= m_wdata_d;
         grant_q    <= grant_d;
         ack_q      <= ack_d;
         p0_rdata_q <= p0_rdata_d;
         p1_rdata_q <= p1_rdata_d;
      end
   end

   assign m_valid  = m_valid_q;
   assign m_wr_rd  = m_wr_rd_q;
   assign m_addr   = m_addr_q;
   assign m_wdata  = m_wdata_q;
   assign p0_ack   = ack_q[0];
   assign p1_ack   = ack_q[1];
   assign p0_rdata = p0_rdata_q;
   assign p1_rdata = p1_rdata_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// tb/tb_mem_arb_ctrl.sv - directed self-checking bench for mem_arb_ctrl

module tb_mem_arb_ctrl;

   localparam int W  = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          res;
   logic          p0_valid, p0_wr_rd, p0_ack;
   logic [AW-1:0] p0_addr;
   logic [W-1:0]  p0_wdata, p0_rdata;
   logic          p1_valid, p1_wr_rd, p1_ack;
   logic [AW-1:0] p1_addr;
   logic [W-1:0]  p1_wdata, p1_rdata;
   logic          m_valid, m_wr_rd, m_ready;
   logic [AW-1:0] m_addr;
   logic [W-1:0]  m_wdata, m_rdata;
   logic          busy;

   always #5 clk = ~clk;

   mem_arb_ctrl #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .res(res),
      .p0_valid(p0_valid), .p0_wr_rd(p0_wr_rd), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_ack(p0_ack), .p0_rdata(p0_rdata),
      .p1_valid(p1_valid), .p1_wr_rd(p1_wr_rd), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ack(p1_ack), .p1_rdata(p1_rdata),
      .m_valid(m_valid), .m_wr_rd(m_wr_rd), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ready(m_ready), .m_rdata(m_rdata), .busy(busy)
   );

   // Memory model: accepts a command when m_valid is seen, answers the next cycle
   // unless stalled; keeps its pending flag across a DUT reset.
   logic [W-1:0] mem [16] = '{default: '0};
   logic         pend = 1'b0;
   logic         stall = 1'b0;
   logic [W-1:0] rdat = '0;

   always @(posedge clk) begin
      if (m_valid) begin
         pend <= 1'b1;
         if (m_wr_rd) mem[m_addr] <= m_wdata;
         rdat <= mem[m_addr];
      end else if (m_ready) begin
         pend <= 1'b0;
      end
   end
   assign m_ready = pend & ~stall;
   assign m_rdata = rdat;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic          v0;
      logic          wr0;
      logic [AW-1:0] a0;
      logic [W-1:0]  d0;
      logic          v1;
      logic          wr1;
      logic [AW-1:0] a1;
      logic [W-1:0]  d1;
      logic          win;
      logic [W-1:0]  rd0;
      logic [W-1:0]  rd1;
   } vec_t;

   vec_t tbl[8];

   task automatic idle_inputs();
      p0_valid = 1'b0; p0_wr_rd = 1'b0; p0_addr = '0; p0_wdata = '0;
      p1_valid = 1'b0; p1_wr_rd = 1'b0; p1_addr = '0; p1_wdata = '0;
   endtask

   // One full transaction from IDLE, checked at every phase.
   task automatic run_txn(input string tag, input vec_t v);
      logic          ewr;
      logic [AW-1:0] ea;
      logic [W-1:0]  ed;
      ewr = v.win ? v.wr1 : v.wr0;
      ea  = v.win ? v.a1  : v.a0;
      ed  = v.win ? v.d1  : v.d0;
      p0_valid = v.v0; p0_wr_rd = v.wr0; p0_addr = v.a0; p0_wdata = v.d0;
      p1_valid = v.v1; p1_wr_rd = v.wr1; p1_addr = v.a1; p1_wdata = v.d1;
      tick();
      check({tag, " issue m_valid"}, 32'(m_valid), 32'd1);
      check({tag, " issue busy"}, 32'(busy), 32'd1);
      check({tag, " m_wr_rd"}, 32'(m_wr_rd), 32'(ewr));
      check({tag, " m_addr"}, 32'(m_addr), 32'(ea));
      if (ewr) check({tag, " m_wdata"}, 32'(m_wdata), 32'(ed));
      tick();
      check({tag, " wait m_valid"}, 32'(m_valid), 32'd0);
      check({tag, " wait acks"}, 32'({p1_ack, p0_ack}), 32'd0);
      tick();
      check({tag, " resp acks"}, 32'({p1_ack, p0_ack}), v.win ? 32'd2 : 32'd1);
      check({tag, " p0_rdata"}, 32'(p0_rdata), 32'(v.rd0));
      check({tag, " p1_rdata"}, 32'(p1_rdata), 32'(v.rd1));
      idle_inputs();
      tick();
      check({tag, " idle acks"}, 32'({p1_ack, p0_ack}), 32'd0);
      check({tag, " idle busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int   ack_port[$];
      int   ack_cyc[$];
      int   n0;
      int   n1;
      vec_t v;

      res = 1'b1;
      idle_inputs();
      tick();
      tick();
      check("rst busy", 32'(busy), 32'd0);
      check("rst m_cmd", 32'({m_valid, m_wr_rd, m_addr, m_wdata}), 32'd0);
      check("rst acks", 32'({p1_ack, p0_ack}), 32'd0);
      check("rst rdata", 32'({p1_rdata, p0_rdata}), 32'd0);
      res = 1'b0;
      tick();

      //            v0    wr0   a0     d0      v1    wr1   a1     d1      win   rd0     rd1
      tbl[0] = '{1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00, 8'h00};
      tbl[1] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 8'h00, 8'hA5};
      tbl[2] = '{1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'hA5, 8'hA5};
`ifdef MEM_ARB_FIXED_PRIO_EN
      tbl[3] = '{1'b1, 1'b1, 4'd5, 8'h3C, 1'b1, 1'b1, 4'd6, 8'hC3, 1'b0, 8'hA5, 8'hA5};
      tbl[4] = '{1'b1, 1'b1, 4'd5, 8'h3C, 1'b1, 1'b0, 4'd6, 8'h00, 1'b0, 8'hA5, 8'hA5};
      tbl[5] = '{1'b1, 1'b0, 4'd5, 8'h00, 1'b1, 1'b0, 4'd6, 8'h00, 1'b0, 8'h3C, 8'hA5};
      tbl[6] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd5, 8'h00, 1'b1, 8'h3C, 8'h3C};
      tbl[7] = '{1'b1, 1'b0, 4'd6, 8'h00, 1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 8'h00, 8'h3C};
`else
      tbl[3] = '{1'b1, 1'b1, 4'd5, 8'h3C, 1'b1, 1'b1, 4'd6, 8'hC3, 1'b1, 8'hA5, 8'hA5};
      tbl[4] = '{1'b1, 1'b1, 4'd5, 8'h3C, 1'b1, 1'b0, 4'd6, 8'h00, 1'b0, 8'hA5, 8'hA5};
      tbl[5] = '{1'b1, 1'b0, 4'd5, 8'h00, 1'b1, 1'b0, 4'd6, 8'h00, 1'b1, 8'hA5, 8'hC3};
      tbl[6] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd5, 8'h00, 1'b1, 8'hA5, 8'h3C};
      tbl[7] = '{1'b1, 1'b0, 4'd6, 8'h00, 1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 8'hC3, 8'h3C};
`endif

      for (int i = 0; i < 8; i++) begin
         run_txn($sformatf("vec%0d", i), tbl[i]);
      end
      check("mem[3] after write", 32'(mem[3]), 32'hA5);

      // Memory stalls for 10 cycles in WAIT; ack comes one cycle after m_ready rises.
      stall = 1'b1;
      p0_valid = 1'b1; p0_wr_rd = 1'b0; p0_addr = 4'd3;
      tick();
      tick();
      for (int i = 0; i < 10; i++) begin
         check($sformatf("stall busy c%0d", i), 32'({busy, p1_ack, p0_ack}), 32'h4);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("stall hold c%0d", i), 32'({busy, p1_ack, p0_ack}), 32'h4);
      end
      stall = 1'b0;
      tick();
      check("stall ack", 32'({p1_ack, p0_ack}), 32'd1);
      check("stall rdata", 32'(p0_rdata), 32'hA5);
      idle_inputs();
      tick();
      check("stall idle", 32'({busy, p1_ack, p0_ack}), 32'd0);

      // Reset while in WAIT aborts the transaction; the late m_ready is ignored.
      stall = 1'b1;
      p0_valid = 1'b1; p0_wr_rd = 1'b0; p0_addr = 4'd5;
      tick();
      tick();
      tick();
      check("abort pre busy", 32'(busy), 32'd1);
      res = 1'b1;
      tick();
      res = 1'b0;
      idle_inputs();
      check("abort busy", 32'(busy), 32'd0);
      check("abort m_valid", 32'(m_valid), 32'd0);
      check("abort acks", 32'({p1_ack, p0_ack}), 32'd0);
      check("abort rdata", 32'(p0_rdata), 32'd0);
      stall = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         check($sformatf("abort ignore c%0d", i), 32'({busy, p1_ack, p0_ack}), 32'd0);
      end
      v = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 8'h00, 8'h00};
      run_txn("post-abort", v);

      // Both ports request continuously for 16 cycles.
      p0_valid = 1'b1; p0_wr_rd = 1'b0; p0_addr = 4'd3;
      p1_valid = 1'b1; p1_wr_rd = 1'b0; p1_addr = 4'd5;
      for (int c = 0; c < 16; c++) begin
         tick();
         if (p0_ack) begin ack_port.push_back(0); ack_cyc.push_back(c); end
         if (p1_ack) begin ack_port.push_back(1); ack_cyc.push_back(c); end
      end
      check("contend ack count", 32'(ack_port.size()), 32'd4);
      for (int k = 0; k < ack_port.size() && k < 4; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         check($sformatf("contend port %0d", k), 32'(ack_port[k]), 32'd0);
`else
         check($sformatf("contend port %0d", k), 32'(ack_port[k]), 32'(k % 2));
`endif
         check($sformatf("contend cycle %0d", k), 32'(ack_cyc[k]), 32'(2 + 4 * k));
      end

      // Port 0 withdraws; port 1 must now be served.
      p0_valid = 1'b0;
      n0 = 0;
      n1 = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (p0_ack) n0++;
         if (p1_ack) begin n1++; p1_valid = 1'b0; end
      end
      check("p1 after p0 drop acks", 32'(n1), 32'd1);
      check("p0 after drop acks", 32'(n0), 32'd0);
      check("p1 served data", 32'(p1_rdata), 32'h3C);
      idle_inputs();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
